schmidl_cox_preamble_inserter: RTL and testbench

Transmit-side counterpart of the Schmidl-Cox metric calculator.
- Prepends a two-half repeated training preamble (half A, then an identical half B) to each outgoing payload frame on an AXI-Stream sample path. A remote receiver's P/R timing metric plateaus on this preamble.
- Sits in the user-logic area of a TX RFNoC block, between the NoC shell payload output and the payload input.
- The preamble half is held in a small writable sample memory that CtrlPort-side logic loads.

---
 rtl/schmidl_cox_pkg.sv | 26 ++
 rtl/schmidl_cox_preamble_inserter_if.sv | 15 +
 rtl/schmidl_cox_preamble_mem.sv | 25 ++
 rtl/schmidl_cox_preamble_inserter.sv | 174 +++++++++++++++++
 tb/tb_schmidl_cox_preamble_inserter.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/schmidl_cox_pkg.sv
// Shared definitions for the Schmidl-Cox TX preamble inserter and the RX
// metric calculator: FSM states, sample layout and the common register map.
package schmidl_cox_pkg;

  localparam int SAMPLE_W = 32;

  // One address map for both directions; the preamble half lives at 0x100.
  localparam int REG_THRESHOLD_ADDR     = 'h000;
  localparam int REG_PACKET_SIZE_ADDR   = 'h004;
  localparam int REG_PREAMBLE_BASE_ADDR = 'h100;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GAP     = 3'd1,
    PRE_A   = 3'd2,
    PRE_B   = 3'd3,
    PAYLOAD = 3'd4
  } state_t;

  // I in the upper half, Q in the lower half, both two's complement.
  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } sample_t;

endpackage

// File: rtl/schmidl_cox_preamble_inserter_if.sv
// AXI-Stream sample link used on both sides of the preamble inserter.
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both 1; once tvalid is raised, tdata/tlast/tvalid hold until that beat
// transfers; tready may depend combinationally on tvalid, never the reverse.
interface schmidl_cox_preamble_inserter_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/schmidl_cox_preamble_mem.sv
// Preamble half storage: one synchronous write port, one combinational read.
// A write lands at the clock edge, so a same-cycle read sees the old word.
module schmidl_cox_preamble_mem #(
  parameter int DATA_W   = 32,
  parameter int HALF_LEN = 64,
  localparam int ADDR_W  = $clog2(HALF_LEN)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [HALF_LEN];

  // Write port: contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/schmidl_cox_preamble_inserter.sv
// Prepends a repeated two-half training preamble (A then identical B) to each
// payload frame. Define SCHMIDL_COX_ZERO_GAP_EN to emit GAP_LEN zero samples
// before each preamble.
module schmidl_cox_preamble_inserter
  import schmidl_cox_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int HALF_LEN = 64
`ifdef SCHMIDL_COX_ZERO_GAP_EN
  , parameter int GAP_LEN = 16
`endif
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic [31:0]                 packet_length,
  input  logic                        cfg_wr_en,
  input  logic [$clog2(HALF_LEN)-1:0] cfg_wr_addr,
  input  logic [DATA_W-1:0]           cfg_wr_data,
  schmidl_cox_preamble_inserter_if.slave  i_axis,
  schmidl_cox_preamble_inserter_if.master o_axis,
  output logic [15:0]                 frame_count,
  output logic                        early_last,
  output state_t                      dbg_state
);

  localparam int ADDR_W = $clog2(HALF_LEN);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(HALF_LEN - 1);
`ifdef SCHMIDL_COX_ZERO_GAP_EN
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);
  logic [GAP_W-1:0] gap_cnt;
`endif

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       plen;
  logic [31:0]       pay_idx;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic [DATA_W-1:0] mem_rd_data;
  logic              load;
  logic              in_fire;
  logic              pay_end;

  // The output register may take a new beat when empty or being drained.
  assign load          = !out_valid || o_axis.tready;
  assign i_axis.tready = (state == PAYLOAD) && load;
  assign in_fire       = i_axis.tvalid && i_axis.tready;
  assign pay_end       = (pay_idx == plen - 32'd1);

  assign o_axis.tdata  = out_data;
  assign o_axis.tvalid = out_valid;
  assign o_axis.tlast  = out_last;
  assign dbg_state     = state;

  schmidl_cox_preamble_mem #(
    .DATA_W   (DATA_W),
    .HALF_LEN (HALF_LEN)
  ) u_mem (
    .clk     (clk),
    .wr_en   (cfg_wr_en),
    .wr_addr (cfg_wr_addr),
    .wr_data (cfg_wr_data),
    .rd_addr (addr),
    .rd_data (mem_rd_data)
  );

  // Framing FSM with the output register; counters only move on a load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      addr        <= '0;
      plen        <= '0;
      pay_idx     <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      frame_count <= '0;
      early_last  <= 1'b0;
`ifdef SCHMIDL_COX_ZERO_GAP_EN
      gap_cnt     <= '0;
`endif
    end else if (clear) begin
      // Abort: drop any in-flight beat; frame_count and memory survive.
      state      <= IDLE;
      addr       <= '0;
      pay_idx    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      early_last <= 1'b0;
`ifdef SCHMIDL_COX_ZERO_GAP_EN
      gap_cnt    <= '0;
`endif
    end else begin
      early_last <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
          // Leaving IDLE consumes nothing; the pending sample waits for PAYLOAD.
          if (i_axis.tvalid) begin
            plen    <= packet_length;
            addr    <= '0;
            pay_idx <= '0;
`ifdef SCHMIDL_COX_ZERO_GAP_EN
            gap_cnt <= '0;
            state   <= GAP;
`else
            state   <= PRE_A;
`endif
          end
        end
`ifdef SCHMIDL_COX_ZERO_GAP_EN
        GAP: if (load) begin
          out_data  <= '0;
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= PRE_A;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
`endif
        PRE_A: if (load) begin
          out_data  <= mem_rd_data;
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          addr      <= addr + 1'b1;
          if (addr == ADDR_LAST) state <= PRE_B;
        end
        PRE_B: if (load) begin
          out_data  <= mem_rd_data;
          out_valid <= 1'b1;
          addr      <= addr + 1'b1;
          // An empty payload closes the frame on the last preamble sample.
          out_last  <= (addr == ADDR_LAST) && (plen == 32'd0);
          if (addr == ADDR_LAST) begin
            if (plen == 32'd0) begin
              state       <= IDLE;
              frame_count <= frame_count + 16'd1;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: if (load) begin
          if (in_fire) begin
            out_data  <= i_axis.tdata;
            out_valid <= 1'b1;
            out_last  <= pay_end || i_axis.tlast;
            pay_idx   <= pay_idx + 32'd1;
            if (pay_end || i_axis.tlast) begin
              state       <= IDLE;
              frame_count <= frame_count + 16'd1;
              early_last  <= !pay_end;
            end
          end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_schmidl_cox_preamble_inserter.sv
// Directed bench for schmidl_cox_preamble_inserter; expectations include the
// zero gap when SCHMIDL_COX_ZERO_GAP_EN is defined.
module tb_schmidl_cox_preamble_inserter;
  import schmidl_cox_pkg::*;

  localparam int DATA_W   = 32;
  localparam int HALF_LEN = 64;
  localparam int W        = DATA_W + 1;
  localparam int BUDGET   = 3000;
`ifdef SCHMIDL_COX_ZERO_GAP_EN
  localparam int GAP_N = 16;
`else
  localparam int GAP_N = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic [31:0] packet_length = '0;
  logic cfg_wr_en = 1'b0;
  logic [$clog2(HALF_LEN)-1:0] cfg_wr_addr = '0;
  logic [DATA_W-1:0] cfg_wr_data = '0;
  logic [15:0] frame_count;
  logic early_last;
  state_t dbg_state;

  always #5 clk = ~clk;

  schmidl_cox_preamble_inserter_if #(.DATA_W(DATA_W)) in_if ();
  schmidl_cox_preamble_inserter_if #(.DATA_W(DATA_W)) out_if ();

  schmidl_cox_preamble_inserter #(.DATA_W(DATA_W), .HALF_LEN(HALF_LEN)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (clear),
    .packet_length (packet_length),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_addr   (cfg_wr_addr),
    .cfg_wr_data   (cfg_wr_data),
    .i_axis        (in_if),
    .o_axis        (out_if),
    .frame_count   (frame_count),
    .early_last    (early_last),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int stall_viol = 0;
  int early_cnt = 0;
  int ready_cnt = 0;
  bit prev_stall = 1'b0;
  logic [W-1:0] prev_word = '0;
  bit rand_ready = 1'b0;

  // Output monitor on the falling edge: collects beats, checks stall stability.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (out_if.tvalid !== 1'b1 || {out_if.tlast, out_if.tdata} !== prev_word))
        stall_viol++;
      if (out_if.tvalid === 1'b1 && out_if.tready === 1'b1)
        got_q.push_back({out_if.tlast, out_if.tdata});
      if (early_last === 1'b1) early_cnt++;
      if (in_if.tready === 1'b1) ready_cnt++;
      prev_stall = (out_if.tvalid === 1'b1) && (out_if.tready === 1'b0);
      prev_word  = {out_if.tlast, out_if.tdata};
    end
  end

  // Downstream ready driver.
  initial begin
    out_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- expected-value builders ----------------
  function automatic logic [31:0] pre_word(input int k);
    logic [15:0] kk;
    kk = 16'(k);
    return {kk, ~kk};
  endfunction

  function automatic void push_pre(input bit last_at_end);
    for (int g = 0; g < GAP_N; g++) exp_q.push_back({1'b0, 32'h0});
    for (int h = 0; h < 2; h++)
      for (int k = 0; k < HALF_LEN; k++)
        exp_q.push_back({last_at_end && h == 1 && k == HALF_LEN - 1, pre_word(k)});
  endfunction

  function automatic void push_pay(input int n, input logic [31:0] base, input int last_idx);
    for (int k = 0; k < n; k++) exp_q.push_back({k == last_idx, base + 32'(k)});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_mem();
    for (int k = 0; k < HALF_LEN; k++) begin
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = 6'(k);
      cfg_wr_data = pre_word(k);
      @(posedge clk);
      #1;
    end
    cfg_wr_en = 1'b0;
  endtask

  task automatic drive_payload(input int n, input int last_idx, input logic [31:0] base, input bit hold);
    for (int k = 0; k < n; k++) begin
      int t;
      in_if.tdata  = base + 32'(k);
      in_if.tlast  = (k == last_idx);
      in_if.tvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (in_if.tready !== 1'b1 && t < BUDGET) begin
        @(negedge clk);
        t++;
      end
      if (t >= BUDGET) begin
        total_cnt++;
        $display("FAIL payload_accept_timeout sample %0d: i_tready never high within %0d cycles", k, BUDGET);
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!hold) begin
      in_if.tvalid = 1'b0;
      in_if.tlast  = 1'b0;
    end
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    if (t >= BUDGET) begin
      total_cnt++;
      $display("FAIL output_timeout got %0d beats, need %0d", got_q.size(), n);
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic new_frame_scoreboard();
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (out_if.tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", out_if.tvalid); else pass_cnt++;
    total_cnt++; if (out_if.tlast !== 1'b0) $display("FAIL reset_tlast got %b want 0", out_if.tlast); else pass_cnt++;
    total_cnt++; if (out_if.tdata !== 32'h0) $display("FAIL reset_tdata got %h want 0", out_if.tdata); else pass_cnt++;
    total_cnt++; if (in_if.tready !== 1'b0) $display("FAIL reset_tready got %b want 0", in_if.tready); else pass_cnt++;
    total_cnt++; if (frame_count !== 16'd0) $display("FAIL reset_frame_count got %0d want 0", frame_count); else pass_cnt++;
    total_cnt++; if (early_last !== 1'b0) $display("FAIL reset_early_last got %b want 0", early_last); else pass_cnt++;
    total_cnt++; if (dbg_state !== IDLE) $display("FAIL reset_state got %0d want %0d", dbg_state, IDLE); else pass_cnt++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    new_frame_scoreboard();
    stall_viol = 0;
    early_cnt = 0;
    packet_length = 32'd4;
    push_pre(1'b0);
    push_pay(4, 32'hD000_0000, 3);
    drive_payload(4, -1, 32'hD000_0000, 1'b0);
    wait_out(exp_q.size());
    total_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL basic_len got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL basic_beat[%0d] got %h want %h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (frame_count !== 16'd1) $display("FAIL basic_frame_count got %0d want 1", frame_count); else pass_cnt++;
    total_cnt++; if (early_cnt !== 0) $display("FAIL basic_early_last got %0d pulses want 0", early_cnt); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    new_frame_scoreboard();
    stall_viol = 0;
    rand_ready = 1'b1;
    packet_length = 32'd4;
    push_pre(1'b0);
    push_pay(4, 32'hD000_0000, 3);
    drive_payload(4, -1, 32'hD000_0000, 1'b0);
    wait_out(exp_q.size());
    rand_ready = 1'b0;
    total_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL bp_len got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL bp_beat[%0d] got %h want %h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (stall_viol !== 0) $display("FAIL bp_stall_stability got %0d changes while stalled want 0", stall_viol); else pass_cnt++;
    total_cnt++; if (frame_count !== 16'd2) $display("FAIL bp_frame_count got %0d want 2", frame_count); else pass_cnt++;
  endtask

  task automatic test_early_last();
    new_frame_scoreboard();
    early_cnt = 0;
    packet_length = 32'd8;
    push_pre(1'b0);
    push_pay(3, 32'hE100_0000, 2);
    drive_payload(3, 2, 32'hE100_0000, 1'b0);
    wait_out(exp_q.size());
    total_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL early_len got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL early_beat[%0d] got %h want %h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (early_cnt !== 1) $display("FAIL early_pulse got %0d pulses want 1", early_cnt); else pass_cnt++;
    total_cnt++; if (frame_count !== 16'd3) $display("FAIL early_frame_count got %0d want 3", frame_count); else pass_cnt++;
    // Following frame must start cleanly from mem[0].
    new_frame_scoreboard();
    packet_length = 32'd2;
    push_pre(1'b0);
    push_pay(2, 32'hE200_0000, 1);
    drive_payload(2, -1, 32'hE200_0000, 1'b0);
    wait_out(exp_q.size());
    total_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL after_early_len got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL after_early_beat[%0d] got %h want %h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (early_cnt !== 1) $display("FAIL after_early_pulse got %0d pulses want 1", early_cnt); else pass_cnt++;
    total_cnt++; if (frame_count !== 16'd4) $display("FAIL after_early_frame_count got %0d want 4", frame_count); else pass_cnt++;
  endtask

  task automatic test_plen_zero();
    new_frame_scoreboard();
    ready_cnt = 0;
    packet_length = 32'd0;
    push_pre(1'b1);
    in_if.tdata  = 32'hBAD0_0001;
    in_if.tvalid = 1'b1;
    @(posedge clk);
    #1;
    in_if.tvalid = 1'b0;
    wait_out(exp_q.size());
    total_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL plen0_len got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL plen0_beat[%0d] got %h want %h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (ready_cnt !== 0) $display("FAIL plen0_tready got %0d ready cycles want 0", ready_cnt); else pass_cnt++;
    total_cnt++; if (frame_count !== 16'd5) $display("FAIL plen0_frame_count got %0d want 5", frame_count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    new_frame_scoreboard();
    packet_length = 32'd2;
    push_pre(1'b0);
    push_pay(2, 32'hF100_0000, 1);
    push_pre(1'b0);
    push_pay(3, 32'hF200_0000, 2);
    drive_payload(2, -1, 32'hF100_0000, 1'b1);
    packet_length = 32'd3;
    drive_payload(3, -1, 32'hF200_0000, 1'b0);
    wait_out(exp_q.size());
    total_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL b2b_len got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL b2b_beat[%0d] got %h want %h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (frame_count !== 16'd7) $display("FAIL b2b_frame_count got %0d want 7", frame_count); else pass_cnt++;
  endtask

  task automatic test_reset_clear();
    int t;
    // Run 1: asynchronous reset in the middle of PRE_B.
    new_frame_scoreboard();
    packet_length = 32'd4;
    in_if.tdata  = 32'hBAD0_0002;
    in_if.tvalid = 1'b1;
    t = 0;
    while (got_q.size() < GAP_N + HALF_LEN + 10 && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    if (t >= BUDGET) begin
      total_cnt++;
      $display("FAIL mid_pre_b_timeout got %0d beats", got_q.size());
    end
    #2;
    reset_n = 1'b0;
    in_if.tvalid = 1'b0;
    #1;
    total_cnt++; if (out_if.tvalid !== 1'b0) $display("FAIL arst_tvalid got %b want 0", out_if.tvalid); else pass_cnt++;
    total_cnt++; if (out_if.tdata !== 32'h0) $display("FAIL arst_tdata got %h want 0", out_if.tdata); else pass_cnt++;
    total_cnt++; if (out_if.tlast !== 1'b0) $display("FAIL arst_tlast got %b want 0", out_if.tlast); else pass_cnt++;
    total_cnt++; if (frame_count !== 16'd0) $display("FAIL arst_frame_count got %0d want 0", frame_count); else pass_cnt++;
    total_cnt++; if (dbg_state !== IDLE) $display("FAIL arst_state got %0d want %0d", dbg_state, IDLE); else pass_cnt++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    load_mem();
    // Run 2: restart from mem[0], then clear mid-PAYLOAD.
    new_frame_scoreboard();
    packet_length = 32'd4;
    push_pre(1'b0);
    push_pay(2, 32'hC100_0000, -1);
    drive_payload(2, -1, 32'hC100_0000, 1'b0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    total_cnt++; if (out_if.tvalid !== 1'b0) $display("FAIL clear_tvalid got %b want 0", out_if.tvalid); else pass_cnt++;
    total_cnt++; if (out_if.tdata !== 32'h0) $display("FAIL clear_tdata got %h want 0", out_if.tdata); else pass_cnt++;
    total_cnt++; if (out_if.tlast !== 1'b0) $display("FAIL clear_tlast got %b want 0", out_if.tlast); else pass_cnt++;
    total_cnt++; if (in_if.tready !== 1'b0) $display("FAIL clear_tready got %b want 0", in_if.tready); else pass_cnt++;
    total_cnt++; if (dbg_state !== IDLE) $display("FAIL clear_state got %0d want %0d", dbg_state, IDLE); else pass_cnt++;
    total_cnt++; if (frame_count !== 16'd0) $display("FAIL clear_frame_count got %0d want 0", frame_count); else pass_cnt++;
    total_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL pre_clear_len got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL pre_clear_beat[%0d] got %h want %h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    @(posedge clk);
    #1;
    // Run 3: frame after clear starts again at mem[0].
    new_frame_scoreboard();
    packet_length = 32'd1;
    push_pre(1'b0);
    push_pay(1, 32'hC200_0000, 0);
    drive_payload(1, -1, 32'hC200_0000, 1'b0);
    wait_out(exp_q.size());
    total_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL post_clear_len got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL post_clear_beat[%0d] got %h want %h", i, got_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (frame_count !== 16'd1) $display("FAIL post_clear_frame_count got %0d want 1", frame_count); else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    in_if.tdata  = '0;
    in_if.tlast  = 1'b0;
    in_if.tvalid = 1'b0;
    test_reset();
    load_mem();
    test_basic();
    test_backpressure();
    test_early_last();
    test_plen_zero();
    test_back_to_back();
    test_reset_clear();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
